// File: rtl/ofdm_channel_equalizer.sv
// One-tap OFDM channel equalizer: learns H[k] from the LTS symbol, then outputs Y[k]*conj(H[k]).
// Three-stage output pipeline (RAM read, complex multiply, shift/saturate) with a global stall.
module ofdm_channel_equalizer #(
   parameter int unsigned                 NUM_SUBCARRIERS = 64,
   parameter logic [NUM_SUBCARRIERS-1:0]  LTS_SIGNS       = '0,
   parameter logic [7:0]                  SR_NUM_SYMBOLS  = 8'd131,
   parameter logic [7:0]                  SR_EQ_SHIFT     = 8'd132
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [31:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready
);

   localparam int unsigned KW = $clog2(NUM_SUBCARRIERS);

   typedef enum logic [0:0] {StTrain, StEq} state_t;

   state_t                state;
   logic [KW-1:0]         k;
   logic [15:0]           sym_cnt;
   logic [15:0]           num_symbols;
   logic [15:0]           frame_limit;
   logic [4:0]            eq_shift;
   logic [31:0]           h_mem [NUM_SUBCARRIERS];

   logic                  s1_valid, s1_last;
   logic [31:0]           s1_y, s1_h;
   logic                  s2_valid, s2_last;
   logic signed [32:0]    s2_re, s2_im;
   logic [4:0]            s2_shift;

   logic                  en, accept, h_we, set_num;
   logic [31:0]           h_wr;
   logic signed [32:0]    yi, yq, hi, hq, re_c, im_c;
   logic [15:0]           sat_re, sat_im;
   logic                  unused_set;

   function automatic logic [15:0] neg_sat(input logic [15:0] v);
      return (v == 16'h8000) ? 16'h7fff : -v;
   endfunction

   function automatic logic [15:0] shift_sat(input logic signed [32:0] v, input logic [4:0] sh);
      logic signed [32:0] s;
      s = v >>> sh;
      if (s > 33'sd32767) return 16'h7fff;
      else if (s < -33'sd32768) return 16'h8000;
      else return s[15:0];
   endfunction

   assign unused_set = ^set_data[31:16];
   assign en         = o_tready | ~o_tvalid;
   assign i_tready   = ~reset & ((state == StTrain) | en);
   assign accept     = i_tvalid & i_tready;
   assign h_we       = accept & (state == StTrain);
   assign set_num    = set_stb & (set_addr == SR_NUM_SYMBOLS);

   always_comb begin
      h_wr = i_tdata;
      if (LTS_SIGNS[k]) h_wr = {neg_sat(i_tdata[31:16]), neg_sat(i_tdata[15:0])};
   end

   always_comb begin
      yi     = 33'($signed(s1_y[31:16]));
      yq     = 33'($signed(s1_y[15:0]));
      hi     = 33'($signed(s1_h[31:16]));
      hq     = 33'($signed(s1_h[15:0]));
      // Operands are sign-extended so 33-bit wraparound arithmetic is exact.
      re_c   = yi * hi + yq * hq;
      im_c   = yq * hi - yi * hq;
      sat_re = shift_sat(s2_re, s2_shift);
      sat_im = shift_sat(s2_im, s2_shift);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         num_symbols <= '0;
         eq_shift    <= '0;
      end else if (set_stb) begin
         if (set_addr == SR_NUM_SYMBOLS) num_symbols <= set_data[15:0];
         if (set_addr == SR_EQ_SHIFT)    eq_shift    <= set_data[4:0];
      end
   end

   // Training writes and equalizer reads never touch the same symbol, so no bypass.
   always_ff @(posedge clk) begin
      if (h_we) h_mem[k] <= h_wr;
      if (en)   s1_h     <= h_mem[k];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StTrain;
         k           <= '0;
         sym_cnt     <= '0;
         frame_limit <= '0;
         s1_valid    <= 1'b0;
         s1_last     <= 1'b0;
         s1_y        <= '0;
         s2_valid    <= 1'b0;
         s2_last     <= 1'b0;
         s2_re       <= '0;
         s2_im       <= '0;
         s2_shift    <= '0;
         o_tvalid    <= 1'b0;
         o_tlast     <= 1'b0;
         o_tdata     <= '0;
      end else if (clear) begin
         state    <= StTrain;
         k        <= '0;
         sym_cnt  <= '0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         o_tvalid <= 1'b0;
      end else begin
         if (accept) begin
            k <= i_tlast ? '0 : k + KW'(1);
            if (state == StTrain) begin
               if (i_tlast) begin
                  state       <= StEq;
                  sym_cnt     <= '0;
                  frame_limit <= set_num ? set_data[15:0] : num_symbols;
               end
            end else if (i_tlast) begin
               sym_cnt <= sym_cnt + 16'd1;
               if (frame_limit != 16'd0 && sym_cnt + 16'd1 == frame_limit) state <= StTrain;
            end
         end
         if (en) begin
            s1_valid <= accept & (state == StEq);
            s1_y     <= i_tdata;
            s1_last  <= i_tlast;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_re    <= re_c;
            s2_im    <= im_c;
            s2_shift <= eq_shift;
            o_tvalid <= s2_valid;
            o_tlast  <= s2_last;
            o_tdata  <= {sat_re, sat_im};
         end
      end
   end

endmodule

// File: tb/tb_ofdm_channel_equalizer.sv
// Scoreboard bench for ofdm_channel_equalizer: a behavioural model queues expected outputs
// on each accepted input beat; a monitor pops and compares on each output handshake.
module tb_ofdm_channel_equalizer;

   localparam int          N     = 64;
   localparam logic [63:0] SIGNS = 64'h8000_0000_0000_0020;

   logic        clk = 1'b0;
   logic        reset, clear, set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [31:0] i_tdata;
   logic        i_tlast, i_tvalid, i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast, o_tvalid;
   logic        o_tready = 1'b1;

   always #5 clk = ~clk;

   ofdm_channel_equalizer #(
      .NUM_SUBCARRIERS (N),
      .LTS_SIGNS       (SIGNS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .i_tvalid (i_tvalid),
      .i_tready (i_tready),
      .o_tdata  (o_tdata),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_out    = 0;
   logic [32:0] exp_q[$];

   logic [31:0] m_h [N];
   int          mk       = 0;
   bit          m_eq_st  = 1'b0;
   int          m_sym    = 0;
   logic [15:0] m_num    = '0;
   logic [15:0] m_limit  = '0;
   int          m_shift  = 0;
   bit          rand_ready = 1'b0;
   bit          sim_set    = 1'b0;
   logic [15:0] sim_val    = '0;

   task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] m_neg(input logic [15:0] x);
      int v;
      v = -int'($signed(x));
      if (v > 32767) v = 32767;
      return v[15:0];
   endfunction

   function automatic logic [15:0] m_sat(input longint v);
      if (v > 32767) return 16'h7fff;
      if (v < -32768) return 16'h8000;
      return 16'(v);
   endfunction

   function automatic logic [31:0] m_eq(input logic [31:0] y, input logic [31:0] h, input int sh);
      longint yi, yq, hi, hq, re, im;
      yi = $signed(y[31:16]);
      yq = $signed(y[15:0]);
      hi = $signed(h[31:16]);
      hq = $signed(h[15:0]);
      re = yi * hi + yq * hq;
      im = yq * hi - yi * hq;
      return {m_sat(re >>> sh), m_sat(im >>> sh)};
   endfunction

   function automatic void model_accept(input logic [31:0] d, input logic l);
      logic [63:0] sg;
      sg = SIGNS;
      if (!m_eq_st) begin
         m_h[mk] = sg[mk] ? {m_neg(d[31:16]), m_neg(d[15:0])} : d;
         if (l) begin
            m_eq_st = 1'b1;
            m_sym   = 0;
            m_limit = m_num;
         end
      end else begin
         exp_q.push_back({l, m_eq(d, m_h[mk], m_shift)});
         if (l) begin
            m_sym++;
            if (m_limit != 16'd0 && m_sym == int'(m_limit)) m_eq_st = 1'b0;
         end
      end
      mk = l ? 0 : (mk + 1) % N;
   endfunction

   always @(posedge clk) begin
      #1;
      o_tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
   end

   always @(negedge clk) begin
      logic [32:0] e;
      if (!reset && o_tvalid && o_tready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", 33'(exp_q.size()), 33'd1);
         end else begin
            e = exp_q.pop_front();
            check_eq("out_data", 33'(o_tdata), 33'(e[31:0]));
            check_eq("out_last", 33'(o_tlast), 33'(e[32]));
         end
      end
   end

   // All tasks start and end just after a rising edge.
   task automatic drive_beat(input logic [31:0] d, input logic l, input int gap);
      int waited;
      while (gap > 0 && $urandom_range(99) < gap) begin
         i_tvalid = 1'b0;
         @(posedge clk); #1;
      end
      i_tvalid = 1'b1;
      i_tdata  = d;
      i_tlast  = l;
      if (sim_set) begin
         set_stb  = 1'b1;
         set_addr = 8'd131;
         set_data = {16'h0, sim_val};
      end
      waited = 0;
      forever begin
         @(negedge clk);
         if (m_eq_st && o_tvalid && !o_tready) check_eq("ready_stall", 33'(i_tready), 33'd0);
         if (i_tready) break;
         @(posedge clk); #1;
         waited++;
         if (waited > 1000) begin
            check_eq("accept_timeout", 33'(waited), 33'd0);
            i_tvalid = 1'b0;
            set_stb  = 1'b0;
            return;
         end
      end
      if (sim_set) m_num = sim_val;
      model_accept(d, l);
      @(posedge clk); #1;
      i_tvalid = 1'b0;
      set_stb  = 1'b0;
   endtask

   task automatic send_symbol(input logic [31:0] fill, input bit rnd, input int gap);
      for (int j = 0; j < N; j++) drive_beat(rnd ? $urandom : fill, j == N - 1, gap);
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      @(posedge clk); #1;
      set_stb = 1'b0;
      if (a == 8'd131) m_num = d[15:0];
      if (a == 8'd132) m_shift = int'(d[4:0]);
   endtask

   task automatic drain;
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) check_eq("drain_timeout", 33'(exp_q.size()), 33'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic model_flush;
      exp_q.delete();
      mk      = 0;
      m_eq_st = 1'b0;
      m_sym   = 0;
   endtask

   task automatic do_clear;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_flush();
   endtask

   initial begin
      int base, lat;
      reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
      i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_i_tready", 33'(i_tready), 33'd0);
      check_eq("rst_o_tvalid", 33'(o_tvalid), 33'd0);
      check_eq("rst_o_tlast",  33'(o_tlast),  33'd0);
      check_eq("rst_o_tdata",  33'(o_tdata),  33'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("train_ready", 33'(i_tready), 33'd1);
      @(posedge clk); #1;

      // Gain/phase with pipeline latency on the first data beat
      write_reg(8'd132, 32'd10);
      send_symbol(32'h03e8_0000, 1'b0, 0);
      drive_beat(32'h0000_01f4, 1'b0, 0);
      lat = 1;
      while (lat < 10) begin
         @(negedge clk);
         if (o_tvalid) break;
         @(posedge clk);
         lat++;
      end
      check_eq("latency", 33'(lat), 33'd3);
      @(posedge clk); #1;
      for (int j = 1; j < N; j++) drive_beat(32'h0000_01f4, j == N - 1, 0);
      drain();
      check_eq("gain_count", 33'(n_out), 33'd64);

      // LTS sign pattern
      do_clear();
      send_symbol(32'h03e8_0000, 1'b0, 0);
      send_symbol(32'h012c_0000, 1'b0, 0);
      drain();

      // Saturation of products and of training negation
      write_reg(8'd132, 32'd0);
      do_clear();
      send_symbol(32'h7fff_7fff, 1'b0, 0);
      send_symbol(32'h7fff_7fff, 1'b0, 0);
      drain();
      do_clear();
      send_symbol(32'h8000_0000, 1'b0, 0);
      send_symbol(32'h0001_0000, 1'b0, 0);
      drain();

      // Framing: two data symbols per frame
      write_reg(8'd132, 32'd10);
      do_clear();
      write_reg(8'd131, 32'd2);
      base = n_out;
      send_symbol(32'h03e8_0000, 1'b0, 0);
      send_symbol(32'h0, 1'b1, 0);
      send_symbol(32'h0, 1'b1, 0);
      send_symbol(32'h0000_03e8, 1'b0, 0);
      send_symbol(32'h0, 1'b1, 0);
      drain();
      check_eq("frame_count", 33'(n_out - base), 33'd192);

      // Settings write coincident with training tlast takes effect for that frame
      do_clear();
      base = n_out;
      for (int j = 0; j < N - 1; j++) drive_beat(32'h03e8_0000, 1'b0, 0);
      sim_set = 1'b1;
      sim_val = 16'd1;
      drive_beat(32'h03e8_0000, 1'b1, 0);
      sim_set = 1'b0;
      send_symbol(32'h0, 1'b1, 0);
      send_symbol(32'h0000_03e8, 1'b0, 0);
      send_symbol(32'h0, 1'b1, 0);
      drain();
      check_eq("simul_count", 33'(n_out - base), 33'd128);
      write_reg(8'd131, 32'd0);

      // Random backpressure and input gaps
      do_clear();
      write_reg(8'd132, 32'd14);
      rand_ready = 1'b1;
      base = n_out;
      send_symbol(32'h0, 1'b1, 50);
      for (int s = 0; s < 100; s++) send_symbol(32'h0, 1'b1, 50);
      drain();
      rand_ready = 1'b0;
      check_eq("bp_count", 33'(n_out - base), 33'd6400);

      // Clear in the middle of a data symbol
      write_reg(8'd132, 32'd10);
      do_clear();
      send_symbol(32'h03e8_0000, 1'b0, 0);
      for (int j = 0; j < 20; j++) drive_beat(32'h012c_0000, 1'b0, 0);
      clear    = 1'b1;
      i_tvalid = 1'b1;
      i_tdata  = 32'h012c_0000;
      i_tlast  = 1'b0;
      @(posedge clk); #1;
      clear    = 1'b0;
      i_tvalid = 1'b0;
      model_flush();
      @(negedge clk);
      check_eq("clear_valid", 33'(o_tvalid), 33'd0);
      @(posedge clk); #1;
      base = n_out;
      send_symbol(32'h0000_03e8, 1'b0, 0);
      repeat (6) @(posedge clk);
      #1;
      check_eq("train_silent", 33'(n_out - base), 33'd0);
      send_symbol(32'h012c_0000, 1'b0, 0);
      drain();
      check_eq("clear_count", 33'(n_out - base), 33'd64);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
